// File: rtl/alu_logic_pkg.sv
// Shared encodings for the ALU logic/shift unit: opcodes, FSM states and shift kinds.
package alu_logic_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_NOR     = 3'b010;
  localparam logic [2:0] OP_XOR     = 3'b011;
  localparam logic [2:0] OP_SLL     = 3'b100;
  localparam logic [2:0] OP_SRL     = 3'b101;
  localparam logic [2:0] OP_SRA     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } shift_kind_e;

  function automatic logic is_shift_op(logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic shift_kind_e op_to_kind(logic [2:0] op);
    case (op)
      OP_SRL:  return SH_SRL;
      OP_SRA:  return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter; SRA replicates the MSB of the incoming value,
// which for an iterative SRA always equals the originally captured sign bit.
module alu_shift_step import alu_logic_pkg::*; #(
  parameter int unsigned REG_SIZE = 32,
  parameter int unsigned SHAMT_W  = $clog2(REG_SIZE)
) (
  input  logic [REG_SIZE-1:0] value,
  input  logic [SHAMT_W-1:0]  k,
  input  logic [1:0]          kind,
  output logic [REG_SIZE-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (kind)
      SH_SLL:  shifted = value << k;
      SH_SRL:  shifted = value >> k;
      SH_SRA:  shifted = $signed(value) >>> k;
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/alu_logic_unit.sv
// Handshaked logic/shift unit: single-cycle bitwise ops, iterative shifts of up to
// SHIFT_STEP bits per cycle, result held in DONE until the consumer takes it.
module alu_logic_unit import alu_logic_pkg::*; #(
  parameter int unsigned REG_SIZE   = 32,
  parameter int unsigned SHIFT_STEP = 4,
  localparam int unsigned SHAMT_W   = $clog2(REG_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [REG_SIZE-1:0] A,
  input  logic [REG_SIZE-1:0] B,
  input  logic [SHAMT_W-1:0]  shamt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_SIZE-1:0] out,
  output logic                zero,
  output logic                err
);

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  state_e              state;
  logic [REG_SIZE-1:0] work;
  logic [SHAMT_W-1:0]  remaining;
  logic [1:0]          kind;
  logic [SHAMT_W-1:0]  step_k;
  logic [REG_SIZE-1:0] shifted;
  logic [REG_SIZE-1:0] bitwise_res;
  logic                accept;

  // In DONE a new op is only taken while the current result is being consumed.
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign step_k    = (remaining > STEP) ? STEP : remaining;

  always_comb begin
    bitwise_res = '0;
    case (op)
      OP_AND:  bitwise_res = A & B;
      OP_OR:   bitwise_res = A | B;
      OP_NOR:  bitwise_res = ~(A | B);
      OP_XOR:  bitwise_res = A ^ B;
      default: bitwise_res = '0;
    endcase
  end

  alu_shift_step #(
    .REG_SIZE (REG_SIZE),
    .SHAMT_W  (SHAMT_W)
  ) u_shift_step (
    .value   (work),
    .k       (step_k),
    .kind    (kind),
    .shifted (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      kind      <= SH_SLL;
      out       <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift_op(op)) begin
              work      <= A;
              remaining <= shamt;
              kind      <= op_to_kind(op);
              if (shamt == '0) begin
                out   <= A;
                zero  <= (A == '0);
                err   <= 1'b0;
                state <= DONE;
              end else begin
                state <= SHIFT;
              end
            end else begin
              out   <= bitwise_res;
              zero  <= (bitwise_res == '0);
              err   <= (op == OP_ILLEGAL);
              state <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work      <= shifted;
          remaining <= remaining - step_k;
          if (remaining == step_k) begin
            out   <= shifted;
            zero  <= (shifted == '0);
            err   <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_logic_unit.md
# alu_logic_unit

Registered, handshaked logic/shift unit for the MIPS ALU datapath, parametrised in word width and shift throughput. It combines the bitwise operations AND, OR, NOR and XOR with iterative SLL, SRL and SRA behind valid/ready handshakes. It sits between operand fetch and the ALU result mux as a multi-cycle functional unit. Bitwise ops take one cycle; shifts take a number of cycles that depends on the shift amount.

## Interface
- REG_SIZE, 32, datapath width in bits (≥ 2)
- SHIFT_STEP, 4, maximum bit positions shifted per cycle (1..REG_SIZE-1)
- SHAMT_W, $clog2(REG_SIZE), derived shift-amount width (localparam)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept
- op  in  3  000 AND, 001 OR, 010 NOR, 011 XOR, 100 SLL, 101 SRL, 110 SRA, 111 illegal
- A  in  REG_SIZE  first operand; the shifted value for shift ops
- B  in  REG_SIZE  second operand; ignored for shifts
- shamt  in  SHAMT_W  shift amount; ignored for bitwise ops
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  REG_SIZE  result
- zero  out  1  out == 0, valid with out_valid
- err  out  1  result came from an illegal op, valid with out_valid

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset (async): state=IDLE, out=0, out_valid=0, zero=0, err=0. in_ready=0 while rst is high, then 1 from the first cycle after deassertion.
- Accept = in_valid && in_ready. Operands are captured on accept; later input changes are ignored.
- Bitwise op accepted:
  - result computed and registered into out; state→DONE.
- Shift op accepted:
  - A is loaded into the work register and shamt into the remaining-count register.
  - If shamt==0, state→DONE with out=A.
  - Otherwise state→SHIFT.
- In SHIFT, each cycle shifts by k = min(SHIFT_STEP, remaining) and decrements remaining by k. At remaining==0, out is loaded and state→DONE.
- Shift fill: SLL and SRL fill with 0; SRA fills with the captured A[REG_SIZE-1].
- Illegal op: out=0, err=1, zero=1, state→DONE.
- In DONE:
  - out_valid=1.
  - out, zero and err are held stable until out_ready=1.
  - When out_ready=1, the result is consumed.
- Result width is always REG_SIZE. Shifts never wrap; bits shifted out are discarded.

## Timing
- in_ready is combinational from state: 1 in IDLE, and 1 in DONE when out_ready=1 (back-to-back pass-through). It is 0 in SHIFT.
- Latency from the accept edge to out_valid: bitwise/illegal 1 cycle; shift 1 + ceil(shamt/SHIFT_STEP) cycles.
- Throughput: bitwise ops sustain one result per cycle when out_ready is held at 1.
- Consume and accept on the same edge in DONE: the new operation starts; out_valid stays 1 only if it is a 1-cycle op, otherwise state→SHIFT and out_valid=0.
- Consume without a new accept: state→IDLE and out_valid=0 on the next cycle.
- Backpressure (out_valid=1 && out_ready=0): no state or output change; in_ready=0.
- rst asserted mid-SHIFT or in DONE: the operation is abandoned and outputs return to reset values immediately. No partial result is ever presented.

## Structure
- Package alu_logic_pkg holds:
  - op encodings (OP_AND … OP_SRA, OP_ILLEGAL);
  - the FSM state enum (IDLE/SHIFT/DONE);
  - the shift-kind enum.
- Sub-module alu_shift_step: a combinational single-step shifter with inputs value, k (SHAMT_W), and kind (SLL/SRL/SRA), and output value shifted by k with the correct fill. It is instantiated once in the SHIFT datapath.
- Bitwise ops stay inline in the top-level result mux.

## Test plan
- Reset with in_valid=1 held: in_ready=0, out_valid=0, out=0 during rst. The first accept happens the cycle after deassertion.
- Stream AND/OR/NOR/XOR with A=0xF0F0_F0F0, B=0xFF00_FF00 and out_ready=1 → results 0xF000_F000, 0xFFF0_FFF0, 0x000F_000F, 0x0FF0_0FF0 on consecutive cycles. XOR of equal operands → zero=1.
- SRA A=0x8000_0000, shamt=4, SHIFT_STEP=4 → out=0xF800_0000 at 2 cycles latency. SRL of the same value → 0x0800_0000.
- SLL A=0x0000_0001, shamt=31 → out=0x8000_0000 at 9 cycles latency. shamt=0 → out=A at 1 cycle latency.
- Hold out_ready=0 for 5 cycles on a result → out, zero and err stay stable and in_ready=0. Releasing out_ready with a queued XOR → same-edge accept.
- op=111 → out=0, err=1, zero=1. rst pulsed mid-SHIFT → out_valid never rises for the aborted operation.
